// File: rtl/ram_bist_pkg.sv
// Shared types for the RAM self-test initiator: FSM state encoding and
// pattern-phase constants.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  localparam logic PH_TRUE = 1'b0;
  localparam logic PH_INV  = 1'b1;

endpackage

// File: rtl/ram_bist_checker.sv
// One-stage read-check pipeline: holds the issued address/expected data until
// the registered RAM read returns, then counts mismatches and keeps the first.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  issue_vld,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [DATA_WIDTH-1:0] issue_exp,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mismatch,
  output logic [ADDR_WIDTH+1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int CW = ADDR_WIDTH + 2;

  logic                  pipe_vld_q,  pipe_vld_d;
  logic [ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;
  logic [DATA_WIDTH-1:0] pipe_exp_q,  pipe_exp_d;
  logic [CW-1:0]         err_cnt_q,   err_cnt_d;
  logic [ADDR_WIDTH-1:0] err_addr_q,  err_addr_d;

  assign mismatch = pipe_vld_q && (mem_rdata != pipe_exp_q);
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    pipe_vld_d  = issue_vld;
    pipe_addr_d = issue_addr;
    pipe_exp_d  = issue_exp;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    if (clear) begin
      pipe_vld_d = 1'b0;
      err_cnt_d  = '0;
      err_addr_d = '0;
    end else if (mismatch) begin
      err_cnt_d = err_cnt_q + CW'(1);
      if (err_cnt_q == '0) err_addr_d = pipe_addr_q;
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together
  // from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
      pipe_exp_q  <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_exp_q  <= pipe_exp_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule

// File: rtl/ram_bist.sv
// RAM self-test initiator: writes (a+OFFSET) to every address, reads and
// checks it, then repeats with the inverted pattern and reports the result.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OFFSET     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;
  logic                  start_q, start_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  we_q,    we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic                  pass_q,  pass_d;
  logic                  clear;
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic ph,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) + DATA_WIDTH'(OFFSET);
    return (ph == PH_INV) ? ~p : p;
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = '0;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    clear   = 1'b0;
    // Start is registered and only captured while idle, so a mid-run pulse is lost.
    start_d = start && !busy_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_q) begin
          state_d = WRITE;
          phase_d = PH_TRUE;
          addr_d  = '0;
          we_d    = 1'b1;
          wdata_d = pattern(PH_TRUE, '0);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          clear   = 1'b1;
        end
      end
      WRITE: begin
        if (addr_q == ADDR_MAX) begin
          state_d = READ;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          we_d    = 1'b1;
          wdata_d = pattern(phase_q, addr_q + ADDR_WIDTH'(1));
        end
      end
      READ: begin
        if (addr_q == ADDR_MAX) state_d = DRAIN;
        else                    addr_d  = addr_q + ADDR_WIDTH'(1);
      end
      DRAIN: begin
        if (phase_q == PH_TRUE) begin
          state_d = WRITE;
          phase_d = PH_INV;
          addr_d  = '0;
          we_d    = 1'b1;
          wdata_d = pattern(PH_INV, '0);
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // The last read is checked on this same edge, so fold it in here.
          pass_d  = (err_cnt == '0) && !mismatch;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_TRUE;
      start_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  ram_bist_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .issue_vld  (state_q == READ),
    .issue_addr (addr_q),
    .issue_exp  (pattern(phase_q, addr_q)),
    .mem_rdata  (mem_rdata),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt),
    .err_addr   (err_addr)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: a registered-read RAM model with selectable faults,
// table-driven full runs, plus restart, mid-run start and mid-run reset cases.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [5:0] err_cnt;
  logic [3:0] err_addr;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  int checks = 0;
  int failures = 0;

  // 0: good RAM, 1: addr 3 bit 0 stuck-at-1, 2: writes to 5 and 9 lost (read 0)
  int mode = 0;
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  ram_bist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .err_addr  (err_addr),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we && !(mode == 2 && (mem_addr == 4'd5 || mem_addr == 4'd9)))
      mem[mem_addr] <= mem_wdata;
    if (mode == 2 && (mem_addr == 4'd5 || mem_addr == 4'd9))
      mem_rdata <= 8'h00;
    else if (mode == 1 && mem_addr == 4'd3)
      mem_rdata <= mem[mem_addr] | 8'h01;
    else
      mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse start for one edge, then count busy cycles and check every write.
  task automatic run_once(input int mode_i, input bit mid, output int cycles);
    int w_idx;
    int guard;
    logic [7:0] exp_d;
    mode = mode_i;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_latency_early", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_we", {31'd0, mem_we}, 32'd1);
    check("start_addr", {28'd0, mem_addr}, 32'd0);
    cycles = 0;
    w_idx = 0;
    guard = 0;
    while (busy && guard < 200) begin
      cycles++;
      guard++;
      if (mem_we) begin
        exp_d = 8'((w_idx % 16) + 10);
        if (w_idx >= 16) exp_d = ~exp_d;
        check("wr_addr", {28'd0, mem_addr}, 32'(w_idx % 16));
        check("wr_data", {24'd0, mem_wdata}, {24'd0, exp_d});
        w_idx++;
      end
      start = (mid && cycles == 20);
      @(negedge clk);
    end
    start = 1'b0;
    check("write_count", 32'(w_idx), 32'd32);
    check("done_after_run", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    int mode;
    bit mid;
    int exp_cnt;
    int exp_addr;
    bit exp_pass;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cycles;
    int guard;
    bit we_seen;

    vecs[0] = '{mode: 0, mid: 1'b0, exp_cnt: 0, exp_addr: 0, exp_pass: 1'b1};
    vecs[1] = '{mode: 1, mid: 1'b0, exp_cnt: 1, exp_addr: 3, exp_pass: 1'b0};
    vecs[2] = '{mode: 2, mid: 1'b0, exp_cnt: 4, exp_addr: 5, exp_pass: 1'b0};
    vecs[3] = '{mode: 0, mid: 1'b1, exp_cnt: 0, exp_addr: 0, exp_pass: 1'b1};

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_err_cnt", {26'd0, err_cnt}, 32'd0);
    check("rst_err_addr", {28'd0, err_addr}, 32'd0);
    check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    we_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we || busy) we_seen = 1'b1;
    end
    check("idle_no_activity", {31'd0, we_seen}, 32'd0);

    // Table-driven full runs
    for (int v = 0; v < 4; v++) begin
      run_once(vecs[v].mode, vecs[v].mid, cycles);
      check("busy_cycles", 32'(cycles), 32'd66);
      check("err_cnt", {26'd0, err_cnt}, 32'(vecs[v].exp_cnt));
      check("err_addr", {28'd0, err_addr}, 32'(vecs[v].exp_addr));
      check("pass", {31'd0, pass}, {31'd0, vecs[v].exp_pass});
    end

    // Start held high in DONE restarts and clears the previous failing result
    run_once(1, 1'b0, cycles);
    check("pre_restart_err_cnt", {26'd0, err_cnt}, 32'd1);
    mode = 0;
    @(negedge clk); start = 1'b1;
    guard = 0;
    while (!busy && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_done_clr", {31'd0, done}, 32'd0);
    check("restart_pass_clr", {31'd0, pass}, 32'd0);
    check("restart_err_clr", {26'd0, err_cnt}, 32'd0);
    check("restart_addr_clr", {28'd0, err_addr}, 32'd0);
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("restart_done", {31'd0, done}, 32'd1);
    check("restart_pass", {31'd0, pass}, 32'd1);
    check("restart_err_cnt", {26'd0, err_cnt}, 32'd0);

    // Reset asserted during phase-0 READ, away from the clock edge
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!busy && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    repeat (20) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    check("pre_reset_reading", {31'd0, mem_we}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_we", {31'd0, mem_we}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_err_cnt", {26'd0, err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_once(0, 1'b0, cycles);
    check("post_reset_cycles", 32'(cycles), 32'd66);
    check("post_reset_pass", {31'd0, pass}, 32'd1);
    check("post_reset_err_cnt", {26'd0, err_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
